npu_cmd_sequencer: RTL and testbench

- Next-generation NPU command controller: accepts descriptor pointers from the softcore and fetches a DESC_WORDS-long descriptor over a handshaked read port.
- Dispatches the job to one of NUM_ACCEL accelerators by the descriptor's accel_id field, then streams that accelerator's result words to memory with backpressure.
- Returns a status response to the softcore; has a progress-timeout watchdog and invalid-ID detection.
- Sits between the softcore bus, the memory arbiter and the accelerator array.

---
 rtl/npu_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_npu_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_cmd_sequencer.sv
// npu_cmd_sequencer
//   Fetches a DESC_WORDS-long job descriptor for the softcore, dispatches it to
//   the accelerator named by accel_id, streams that accelerator's result beats
//   to memory under write backpressure, and returns a status response.
//   A progress watchdog aborts jobs that stall, and unknown accel_ids are
//   rejected without touching any accelerator.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_*               softcore command (descriptor base address)
//   timeout_limit       watchdog limit in RUN cycles, 0 disables
//   rsp_*               softcore response: status 00 ok / 10 bad id / 11 timeout
//   mem_rd_*            descriptor read port (request handshake + returned data)
//   mem_wr_*            result write port (valid/ready)
//   acc_start/abort     one-hot control pulses to the accelerator array
//   acc_cmd/in/w/b      descriptor words 0..3, held until the next dispatch
//   acc_res_*, acc_done result beat stream and completion from accelerators
//   busy, err_count     status: not idle, saturating count of error responses
module npu_cmd_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_ACCEL  = 4,
    parameter int DESC_WORDS = 6,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ADDR_WIDTH-1:0]           cmd_desc_addr,
    input  logic [TIMEOUT_W-1:0]            timeout_limit,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [1:0]                      rsp_status,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            mem_rd_valid,
    input  logic                            mem_rd_ready,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic                            mem_rd_rvalid,
    input  logic [DATA_WIDTH-1:0]           mem_rd_data,
    output logic                            mem_wr_valid,
    input  logic                            mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic [NUM_ACCEL-1:0]            acc_start,
    output logic [NUM_ACCEL-1:0]            acc_abort,
    output logic [DATA_WIDTH-1:0]           acc_cmd,
    output logic [ADDR_WIDTH-1:0]           acc_in_addr,
    output logic [ADDR_WIDTH-1:0]           acc_w_addr,
    output logic [ADDR_WIDTH-1:0]           acc_b_addr,
    input  logic [NUM_ACCEL-1:0]            acc_res_valid,
    input  logic [NUM_ACCEL*DATA_WIDTH-1:0] acc_res_data,
    output logic [NUM_ACCEL-1:0]            acc_res_ready,
    input  logic [NUM_ACCEL-1:0]            acc_done,
    output logic                            busy,
    output logic [7:0]                      err_count
);

    localparam int SEL_W  = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1;
    localparam int WIDX_W = $clog2(DESC_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_DISPATCH, S_RUN, S_RESP
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [WIDX_W-1:0]       widx;
    logic [DATA_WIDTH-1:0]   desc_cmd;
    logic [ADDR_WIDTH-1:0]   desc_in, desc_w, desc_b, desc_out;
    logic [DATA_WIDTH-1:0]   desc_cnt;
    logic [SEL_W-1:0]        sel;
    logic [DATA_WIDTH-1:0]   k;          // same width as output_count, cannot overflow
    logic [TIMEOUT_W-1:0]    timer;
    logic                    done_seen;

    logic                    wr_free;
    logic                    beat_ok;
    logic                    beat_acc;
    logic                    done_now;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   beat;
    logic [SEL_W-1:0]        id_sel;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // A new beat may only be taken when the write slot is empty or draining now,
    // so a stalled write keeps its address/data and no beat is lost.
    assign wr_free     = !mem_wr_valid || mem_wr_ready;
    assign beat_ok     = (state == S_RUN) && (k < desc_cnt) && wr_free;
    assign beat        = acc_res_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign beat_acc    = beat_ok && acc_res_valid[sel];
    assign done_now    = done_seen || acc_done[sel];
    assign timeout_hit = (timeout_limit != '0) && (timer == timeout_limit);
    assign id_sel      = desc_cmd[8 +: SEL_W];

    always_comb begin
        acc_res_ready      = '0;
        acc_res_ready[sel] = beat_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            base_addr    <= '0;
            widx         <= '0;
            desc_cmd     <= '0;
            desc_in      <= '0;
            desc_w       <= '0;
            desc_b       <= '0;
            desc_out     <= '0;
            desc_cnt     <= '0;
            sel          <= '0;
            k            <= '0;
            timer        <= '0;
            done_seen    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_status   <= 2'b00;
            rsp_data     <= '0;
            mem_rd_valid <= 1'b0;
            mem_rd_addr  <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            acc_start    <= '0;
            acc_abort    <= '0;
            acc_cmd      <= '0;
            acc_in_addr  <= '0;
            acc_w_addr   <= '0;
            acc_b_addr   <= '0;
            err_count    <= '0;
        end else begin
            acc_start <= '0;
            acc_abort <= '0;

            // Write slot runs independently of the FSM so a write still pending
            // at a timeout drains while the response waits in RESP.
            if (beat_acc) begin
                mem_wr_valid <= 1'b1;
                mem_wr_addr  <= desc_out + (ADDR_WIDTH'(k) << 2);
                mem_wr_data  <= beat;
            end else if (mem_wr_ready) begin
                mem_wr_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base_addr    <= cmd_desc_addr;
                        widx         <= '0;
                        mem_rd_valid <= 1'b1;
                        mem_rd_addr  <= cmd_desc_addr;
                        state        <= S_FETCH;
                    end
                end

                // mem_rd_valid high: request phase; low: waiting for the data beat.
                S_FETCH: begin
                    if (mem_rd_valid) begin
                        if (mem_rd_ready) mem_rd_valid <= 1'b0;
                    end else if (mem_rd_rvalid) begin
                        if      (widx == WIDX_W'(0)) desc_cmd <= mem_rd_data;
                        else if (widx == WIDX_W'(1)) desc_in  <= ADDR_WIDTH'(mem_rd_data);
                        else if (widx == WIDX_W'(2)) desc_w   <= ADDR_WIDTH'(mem_rd_data);
                        else if (widx == WIDX_W'(3)) desc_b   <= ADDR_WIDTH'(mem_rd_data);
                        else if (widx == WIDX_W'(4)) desc_out <= ADDR_WIDTH'(mem_rd_data);
                        else if (widx == WIDX_W'(5)) desc_cnt <= mem_rd_data;
                        if (widx == WIDX_W'(DESC_WORDS - 1)) begin
                            state <= S_CHECK;
                        end else begin
                            widx         <= widx + WIDX_W'(1);
                            mem_rd_valid <= 1'b1;
                            mem_rd_addr  <= base_addr + (ADDR_WIDTH'(widx + WIDX_W'(1)) << 2);
                        end
                    end
                end

                S_CHECK: begin
                    if (desc_cmd[15:8] >= 8'(NUM_ACCEL)) begin
                        rsp_status <= 2'b10;
                        rsp_data   <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        acc_cmd     <= desc_cmd;
                        acc_in_addr <= desc_in;
                        acc_w_addr  <= desc_w;
                        acc_b_addr  <= desc_b;
                        sel         <= id_sel;
                        acc_start   <= NUM_ACCEL'(1) << id_sel;
                        state       <= S_DISPATCH;
                    end
                end

                S_DISPATCH: begin
                    k         <= '0;
                    done_seen <= 1'b0;
                    timer     <= '0;
                    rsp_data  <= '0;
                    state     <= S_RUN;
                end

                S_RUN: begin
                    if (beat_acc) begin
                        k <= k + 1'b1;
                        if (k == '0) rsp_data <= beat;
                    end
                    if (acc_done[sel]) done_seen <= 1'b1;
                    // Any sign of progress restarts the watchdog; saturate otherwise.
                    if (beat_acc || acc_done[sel])    timer <= '0;
                    else if (timer != '1)              timer <= timer + 1'b1;

                    if ((k == desc_cnt) && done_now && wr_free) begin
                        rsp_status <= 2'b00;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (!beat_acc && !acc_done[sel] && timeout_hit) begin
                        acc_abort  <= NUM_ACCEL'(1) << sel;
                        rsp_status <= 2'b11;
                        rsp_data   <= '0;
                        rsp_valid  <= wr_free;
                        state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_valid) begin
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            if (rsp_status != 2'b00 && err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                            state <= S_IDLE;
                        end
                    end else if (wr_free) begin
                        rsp_valid <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_cmd_sequencer.sv
module tb_npu_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_desc_addr;
    logic [15:0]  timeout_limit;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_status;
    logic [31:0]  rsp_data;
    logic         mem_rd_valid;
    logic         mem_rd_ready;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_rvalid;
    logic [31:0]  mem_rd_data;
    logic         mem_wr_valid;
    logic         mem_wr_ready;
    logic [31:0]  mem_wr_addr;
    logic [31:0]  mem_wr_data;
    logic [3:0]   acc_start;
    logic [3:0]   acc_abort;
    logic [31:0]  acc_cmd;
    logic [31:0]  acc_in_addr;
    logic [31:0]  acc_w_addr;
    logic [31:0]  acc_b_addr;
    logic [3:0]   acc_res_valid;
    logic [127:0] acc_res_data;
    logic [3:0]   acc_res_ready;
    logic [3:0]   acc_done;
    logic         busy;
    logic [7:0]   err_count;

    npu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_desc_addr(cmd_desc_addr),
        .timeout_limit(timeout_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rvalid(mem_rd_rvalid), .mem_rd_data(mem_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .acc_start(acc_start), .acc_abort(acc_abort), .acc_cmd(acc_cmd),
        .acc_in_addr(acc_in_addr), .acc_w_addr(acc_w_addr), .acc_b_addr(acc_b_addr),
        .acc_res_valid(acc_res_valid), .acc_res_data(acc_res_data),
        .acc_res_ready(acc_res_ready), .acc_done(acc_done),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- descriptor memory + read responder ----------------
    logic [31:0] dmem [logic [31:0]];
    logic        rd_hs;
    logic [31:0] rd_a;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        rd_hs = mem_rd_valid && mem_rd_ready;
        rd_a  = mem_rd_addr;
        #1;
        mem_rd_rvalid = rd_hs;
        mem_rd_data   = rd_hs ? rd_mem(rd_a) : 32'h0;
        mem_rd_ready  = ($urandom_range(0, 3) != 0);
    end

    // ---------------- accelerator model ----------------
    logic [31:0] beat_tab [0:4];
    logic [31:0] m_beats [$];
    int  m_id, m_limit, m_bdly, m_dmode, m_ddly, m_need, m_cyc, m_sent;
    bit  m_run;
    logic m_pop, m_st;

    always @(posedge clk) begin
        m_pop = m_run && acc_res_valid[m_id] && acc_res_ready[m_id];
        m_st  = acc_start[m_id];
        #1;
        if (m_st) begin m_run = 1; m_cyc = 0; m_sent = 0; end
        else if (m_run) m_cyc++;
        if (m_pop) begin void'(m_beats.pop_front()); m_sent++; end
        acc_res_valid = '0;
        acc_res_data  = '0;
        acc_done      = '0;
        if (m_run) begin
            if (m_beats.size() > 0 && m_sent < m_limit && m_cyc >= m_bdly) begin
                acc_res_valid[m_id]          = 1'b1;
                acc_res_data[m_id*32 +: 32]  = m_beats[0];
            end
            case (m_dmode)
                0: if (m_sent >= m_need) acc_done[m_id] = 1'b1;   // level after last beat
                1: if (m_cyc == m_ddly)  acc_done[m_id] = 1'b1;   // single pulse
                default: ;
            endcase
        end
    end

    // ---------------- monitors ----------------
    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    int start_cnt, abort_cnt, abort_edge, beat_edge;
    logic [3:0] start_val, abort_val;

    always @(negedge clk) begin
        if (mem_wr_valid && mem_wr_ready) begin
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
        end
        if (acc_start != 0) begin start_cnt++; start_val = acc_start; end
        if (acc_abort != 0) begin abort_cnt++; abort_val = acc_abort; abort_edge = cyc_n; end
        if ((acc_res_valid & acc_res_ready) != 0) beat_edge = cyc_n + 1;
    end

    // ---------------- helpers ----------------
    task automatic setup_job(input logic [31:0] base, input logic [7:0] id, input logic [31:0] oaddr,
                             input logic [31:0] cnt, input int nbeats, input int bdly, input int dmode,
                             input int ddly, input int limit, input logic [15:0] tlim);
        dmem[base]        = {16'h0, id, 8'h5A};
        dmem[base + 4]    = base + 32'h1000;
        dmem[base + 8]    = base + 32'h2000;
        dmem[base + 12]   = base + 32'h3000;
        dmem[base + 16]   = oaddr;
        dmem[base + 20]   = cnt;
        m_run   = 0;
        m_id    = (id < 4) ? int'(id) : 0;
        m_beats.delete();
        for (int i = 0; i < nbeats; i++) m_beats.push_back(beat_tab[i]);
        m_limit = limit; m_bdly = bdly; m_dmode = dmode; m_ddly = ddly; m_need = int'(cnt);
        wa_q.delete(); wd_q.delete();
        start_cnt = 0; abort_cnt = 0; start_val = 0; abort_val = 0;
        abort_edge = 0; beat_edge = 0;
        timeout_limit = tlim;
    endtask

    task automatic issue(input logic [31:0] base);
        @(posedge clk) #1;
        cmd_valid = 1; cmd_desc_addr = base;
        @(posedge clk) #1;
        cmd_valid = 0;
        @(negedge clk);
        chk("fetch_first_valid", mem_rd_valid, 1);
        chk("fetch_first_addr", mem_rd_addr, base);
    endtask

    task automatic wait_rsp(input logic [1:0] est, input logic [31:0] edata);
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 400 cycles");
        end else begin
            chk("rsp_status", rsp_status, est);
            chk("rsp_data", rsp_data, edata);
        end
        @(posedge clk) #1; rsp_ready = 1;
        @(posedge clk) #1; rsp_ready = 0;
        @(negedge clk);
    endtask

    task automatic chk_writes(input logic [31:0] oaddr, input int ewr);
        logic [31:0] ea;
        chk("write_count", wa_q.size(), ewr);
        for (int i = 0; i < ewr && i < wa_q.size(); i++) begin
            ea = oaddr + 32'(4 * i);
            chk("write_addr", wa_q[i], ea);
            chk("write_data", wd_q[i], beat_tab[i]);
        end
    endtask

    typedef struct {
        logic [31:0] base; logic [7:0] id; logic [31:0] oaddr; logic [31:0] cnt;
        int nbeats; int bdly; int dmode; int ddly;
        logic [1:0] est; logic [31:0] edata; int ewr; logic [3:0] estart; logic [7:0] eerr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        beat_tab[0] = 32'hAA; beat_tab[1] = 32'hBB; beat_tab[2] = 32'hCC;
        beat_tab[3] = 32'hDD; beat_tab[4] = 32'hEE;

        //         base      id    oaddr          cnt nb bd dm dd  st     data   wr start    err
        vecs[0] = '{32'h100, 8'd2, 32'h2000,      3,  4, 0, 0, 0, 2'b00, 32'hAA, 3, 4'b0100, 8'd0};
        vecs[1] = '{32'h200, 8'd7, 32'h2400,      2,  2, 0, 0, 0, 2'b10, 32'h0,  0, 4'b0000, 8'd1};
        vecs[2] = '{32'h300, 8'd0, 32'h2800,      0,  2, 0, 1, 3, 2'b00, 32'h0,  0, 4'b0001, 8'd1};
        vecs[3] = '{32'h400, 8'd1, 32'h2C00,      2,  2, 6, 1, 1, 2'b00, 32'hAA, 2, 4'b0010, 8'd1};
        vecs[4] = '{32'h500, 8'd3, 32'hFFFFFFFC,  2,  2, 0, 0, 0, 2'b00, 32'hAA, 2, 4'b1000, 8'd1};
        vecs[5] = '{32'h600, 8'd4, 32'h3000,      1,  1, 0, 0, 0, 2'b10, 32'h0,  0, 4'b0000, 8'd2};

        rst = 1; cmd_valid = 0; cmd_desc_addr = 0; timeout_limit = 0; rsp_ready = 0;
        mem_rd_ready = 1; mem_rd_rvalid = 0; mem_rd_data = 0; mem_wr_ready = 1;
        acc_res_valid = 0; acc_res_data = 0; acc_done = 0;
        m_run = 0; m_id = 0; m_limit = 0; m_bdly = 0; m_dmode = 2; m_ddly = 0; m_need = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rd_valid", mem_rd_valid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_err_count", err_count, 0);
        @(posedge clk) #1; rst = 0;

        // ---------------- table-driven jobs ----------------
        foreach (vecs[n]) begin
            setup_job(vecs[n].base, vecs[n].id, vecs[n].oaddr, vecs[n].cnt, vecs[n].nbeats,
                      vecs[n].bdly, vecs[n].dmode, vecs[n].ddly, 99, 16'd0);
            issue(vecs[n].base);
            wait_rsp(vecs[n].est, vecs[n].edata);
            chk("err_count", err_count, vecs[n].eerr);
            chk_writes(vecs[n].oaddr, vecs[n].ewr);
            chk("start_pulses", start_cnt, (vecs[n].estart != 0) ? 1 : 0);
            chk("start_onehot", start_val, vecs[n].estart);
            chk("abort_none", abort_cnt, 0);
            if (vecs[n].est == 2'b00) begin
                chk("acc_cmd", acc_cmd, {16'h0, vecs[n].id, 8'h5A});
                chk("acc_in_addr", acc_in_addr, vecs[n].base + 32'h1000);
                chk("acc_w_addr", acc_w_addr, vecs[n].base + 32'h2000);
                chk("acc_b_addr", acc_b_addr, vecs[n].base + 32'h3000);
            end
        end

        // ---------------- write backpressure mid-stream ----------------
        setup_job(32'h800, 8'd0, 32'h4000, 4, 4, 0, 0, 0, 99, 16'd0);
        issue(32'h800);
        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk) #1;
                if (wa_q.size() >= 1) begin seen = 1; break; end
            end
            chk("stall_first_write_seen", seen, 1);
        end
        mem_wr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wr_valid", mem_wr_valid, 1);
            chk("stall_res_ready", acc_res_ready, 4'b0000);
            chk("stall_wr_addr", mem_wr_addr, 32'h4004);
            chk("stall_wr_data", mem_wr_data, 32'hBB);
        end
        @(posedge clk) #1; mem_wr_ready = 1;
        wait_rsp(2'b00, 32'hAA);
        chk_writes(32'h4000, 4);
        chk("stall_err_count", err_count, 2);

        // ---------------- watchdog ----------------
        setup_job(32'h900, 8'd1, 32'h5000, 3, 3, 0, 2, 0, 1, 16'd20);
        issue(32'h900);
        wait_rsp(2'b11, 32'h0);
        chk("timeout_abort_pulses", abort_cnt, 1);
        chk("timeout_abort_onehot", abort_val, 4'b0010);
        chk("timeout_abort_delay", abort_edge - beat_edge, 21);
        chk_writes(32'h5000, 1);
        chk("timeout_err_count", err_count, 3);
        timeout_limit = 0;

        // ---------------- reset during RUN ----------------
        setup_job(32'hA00, 8'd2, 32'h6000, 3, 3, 1000, 2, 0, 99, 16'd0);
        issue(32'hA00);
        begin
            bit started = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (start_cnt > 0) begin started = 1; break; end
            end
            chk("rst_job_started", started, 1);
        end
        repeat (3) @(posedge clk);
        #1; rst = 1;
        @(posedge clk) #1;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_wr_valid", mem_wr_valid, 0);
        chk("midrst_res_ready", acc_res_ready, 4'b0000);
        chk("midrst_acc_cmd", acc_cmd, 32'h0);
        chk("midrst_err_count", err_count, 0);
        @(posedge clk) #1; rst = 0; m_run = 0;
        repeat (5) @(negedge clk);
        chk("midrst_abort_none", abort_cnt, 0);
        chk("midrst_old_writes", wa_q.size(), 0);

        setup_job(32'hB00, 8'd1, 32'h7000, 1, 1, 0, 0, 0, 99, 16'd0);
        issue(32'hB00);
        wait_rsp(2'b00, 32'hAA);
        chk_writes(32'h7000, 1);
        chk("post_rst_start", start_val, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
